// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy attack scheduler.
package enemy_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARN   = 2'd1,
      STRIKE = 2'd2,
      COOL   = 2'd3
   } state_e;

   localparam logic [4:0] LANE_A_DEF   = 5'd0;
   localparam logic [4:0] LANE_B_DEF   = 5'd10;
   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS    = 8'hB8;
   localparam logic [7:0] LFSR_SEED_NZ = 8'hA5;
   localparam int unsigned CNT_W       = 16;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/enemy_lfsr8.sv
// 8-bit Fibonacci LFSR advancing on each game tick; a zero seed is remapped
// so the register can never lock up in the all-zero state.
module enemy_lfsr8
   import enemy_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] q_q;
   logic [7:0] q_d;
   logic [7:0] seed_eff;

   always_comb begin
      seed_eff = (seed == 8'h00) ? LFSR_SEED_NZ : seed;
      if (adv) begin
         q_d = lfsr_next(q_q);
      end else begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q <= seed_eff;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/enemy_attack_sched.sv
// Enemy attack scheduler: round-robin target, LFSR-chosen lane, and a
// warn -> strike -> cooldown sequence issuing at most one damage pulse per attack.
module enemy_attack_sched
   import enemy_pkg::*;
#(
   parameter int unsigned       POS_W        = 5,
   parameter logic [POS_W-1:0]  LANE_A       = POS_W'(LANE_A_DEF),
   parameter logic [POS_W-1:0]  LANE_B       = POS_W'(LANE_B_DEF),
   parameter int unsigned       WARN_TICKS   = 8,
   parameter int unsigned       STRIKE_TICKS = 4,
   parameter int unsigned       COOL_TICKS   = 16,
   parameter logic [7:0]        SEED         = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             enable,
   input  logic [POS_W-1:0] pos_0,
   input  logic [POS_W-1:0] pos_1,
   input  logic             hit_0,
   input  logic             hit_1,
   output logic             target,
   output logic             atk_lane,
   output logic             warn,
   output logic             strike,
   output logic             damage_0,
   output logic             damage_1,
   output logic [7:0]       attack_cnt
);

   localparam logic [CNT_W-1:0] WARN_LOAD   = CNT_W'(WARN_TICKS - 1);
   localparam logic [CNT_W-1:0] STRIKE_LOAD = CNT_W'(STRIKE_TICKS - 1);
   localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOL_TICKS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rr_q, rr_d;
   logic             target_q, target_d;
   logic             lane_q, lane_d;
   logic [7:0]       attack_cnt_q, attack_cnt_d;
   logic             dmg_done_q, dmg_done_d;
   logic             dmg0_q, dmg0_d;
   logic             dmg1_q, dmg1_d;
   logic             warn_q, strike_q;
   logic [7:0]       lfsr_s;
   logic [POS_W-1:0] lane_pos_s;
   logic [POS_W-1:0] tgt_pos_s;
   logic             tgt_hit_s;
   logic             cnt_zero_s;

   enemy_lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .adv  (tick),
      .seed (SEED),
      .q    (lfsr_s)
   );

   always_comb begin
      lane_pos_s = lane_q ? LANE_B : LANE_A;
      if (target_q) begin
         tgt_pos_s = pos_1;
         tgt_hit_s = hit_1;
      end else begin
         tgt_pos_s = pos_0;
         tgt_hit_s = hit_0;
      end
      cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_d         = rr_q;
      target_d     = target_q;
      lane_d       = lane_q;
      attack_cnt_d = attack_cnt_q;
      dmg_done_d   = dmg_done_q;
      dmg0_d       = 1'b0;
      dmg1_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && enable) begin
               state_d  = WARN;
               target_d = rr_q;
               lane_d   = lfsr_s[0];
               cnt_d    = WARN_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         WARN: begin
            // Abort wins over a coinciding final warn tick
            if (!enable) begin
               state_d = IDLE;
            end else if (tick) begin
               if (cnt_zero_s) begin
                  state_d    = STRIKE;
                  cnt_d      = STRIKE_LOAD;
                  dmg_done_d = 1'b0;
                  if (attack_cnt_q != 8'hFF) begin
                     attack_cnt_d = attack_cnt_q + 8'd1;
                  end else begin
                     attack_cnt_d = attack_cnt_q;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               state_d = WARN;
            end
         end
         STRIKE: begin
            if (!dmg_done_q && (tgt_pos_s == lane_pos_s) && !tgt_hit_s) begin
               dmg_done_d = 1'b1;
               if (target_q) begin
                  dmg1_d = 1'b1;
               end else begin
                  dmg0_d = 1'b1;
               end
            end else begin
               dmg_done_d = dmg_done_q;
            end
            if (tick) begin
               if (cnt_zero_s) begin
                  state_d = COOL;
                  cnt_d   = COOL_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               state_d = STRIKE;
            end
         end
         COOL: begin
            if (tick) begin
               if (cnt_zero_s) begin
                  state_d = IDLE;
                  rr_d    = ~rr_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               state_d = COOL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // warn/strike are derived from the next state so they track the state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         rr_q         <= 1'b0;
         target_q     <= 1'b0;
         lane_q       <= 1'b0;
         attack_cnt_q <= 8'd0;
         dmg_done_q   <= 1'b0;
         dmg0_q       <= 1'b0;
         dmg1_q       <= 1'b0;
         warn_q       <= 1'b0;
         strike_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_q         <= rr_d;
         target_q     <= target_d;
         lane_q       <= lane_d;
         attack_cnt_q <= attack_cnt_d;
         dmg_done_q   <= dmg_done_d;
         dmg0_q       <= dmg0_d;
         dmg1_q       <= dmg1_d;
         warn_q       <= (state_d == WARN);
         strike_q     <= (state_d == STRIKE);
      end
   end

   assign target     = target_q;
   assign atk_lane   = lane_q;
   assign warn       = warn_q;
   assign strike     = strike_q;
   assign damage_0   = dmg0_q;
   assign damage_1   = dmg1_q;
   assign attack_cnt = attack_cnt_q;

endmodule

// File: tb/tb_enemy_attack_sched.sv
// Directed self-checking bench for enemy_attack_sched with default parameters.
module tb_enemy_attack_sched;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       enable;
   logic [4:0] pos_0;
   logic [4:0] pos_1;
   logic       hit_0;
   logic       hit_1;
   logic       target;
   logic       atk_lane;
   logic       warn;
   logic       strike;
   logic       damage_0;
   logic       damage_1;
   logic [7:0] attack_cnt;

   int         checks = 0;
   int         errors = 0;
   int         dmg0_n = 0;
   int         dmg1_n = 0;
   int         both_n = 0;
   logic [7:0] lfsr_m;
   logic       exp_lane;

   enemy_attack_sched dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .enable     (enable),
      .pos_0      (pos_0),
      .pos_1      (pos_1),
      .hit_0      (hit_0),
      .hit_1      (hit_1),
      .target     (target),
      .atk_lane   (atk_lane),
      .warn       (warn),
      .strike     (strike),
      .damage_0   (damage_0),
      .damage_1   (damage_1),
      .attack_cnt (attack_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (damage_0 === 1'b1) dmg0_n <= dmg0_n + 1;
      if (damage_1 === 1'b1) dmg1_n <= dmg1_n + 1;
      if (damage_0 === 1'b1 && damage_1 === 1'b1) both_n <= both_n + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic fb;
      fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {v[6:0], fb};
   endfunction

   function automatic logic [4:0] lane_of(input logic l);
      return l ? 5'd10 : 5'd0;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      lfsr_m = lfsr_step(lfsr_m);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0; enable = 1'b0;
      pos_0 = 5'd31; pos_1 = 5'd31; hit_0 = 1'b0; hit_1 = 1'b0;
      lfsr_m = 8'hA5;

      // 1. reset held with tick toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tick = ~tick;
      end
      @(negedge clk);
      tick = 1'b0;
      check("rst_warn",     16'(warn),       16'd0);
      check("rst_strike",   16'(strike),     16'd0);
      check("rst_target",   16'(target),     16'd0);
      check("rst_lane",     16'(atk_lane),   16'd0);
      check("rst_dmg0",     16'(damage_0),   16'd0);
      check("rst_dmg1",     16'(damage_1),   16'd0);
      check("rst_atkcnt",   16'(attack_cnt), 16'd0);
      rst = 1'b1;

      // 2. full attack on player 0, lane A (lfsr A5 -> 4A gives lane bit 0)
      pos_0 = 5'd0;
      do_tick();
      check("idle_no_enable", 16'(warn), 16'd0);
      enable = 1'b1;
      do_tick();
      check("t2_warn",   16'(warn),     16'd1);
      check("t2_target", 16'(target),   16'd0);
      check("t2_lane",   16'(atk_lane), 16'd0);
      ticks(7);
      check("t2_warn_len7", 16'(warn),   16'd1);
      check("t2_nostrike7", 16'(strike), 16'd0);
      do_tick();
      check("t2_strike",     16'(strike),     16'd1);
      check("t2_warn_off",   16'(warn),       16'd0);
      check("t2_atkcnt",     16'(attack_cnt), 16'd1);
      check("t2_dmg_early",  16'(damage_0),   16'd0);
      @(negedge clk);
      check("t2_dmg_pulse",  16'(damage_0),   16'd1);
      @(negedge clk);
      check("t2_dmg_end",    16'(damage_0),   16'd0);
      ticks(3);
      check("t2_strike_len3", 16'(strike), 16'd1);
      do_tick();
      check("t2_cool",     16'(strike), 16'd0);
      check("t2_dmg0_cnt", 16'(dmg0_n), 16'd1);
      check("t2_dmg1_cnt", 16'(dmg1_n), 16'd0);
      pos_0 = 5'd31;
      ticks(16);
      check("t2_cool_idle", 16'(warn), 16'd0);
      exp_lane = lfsr_m[0];
      do_tick();
      check("t2_next_warn",   16'(warn),     16'd1);
      check("t2_next_target", 16'(target),   16'd1);
      check("t2_next_lane",   16'(atk_lane), 16'(exp_lane));

      // 4. player-1 attack, wrong lane then moved onto the lane in the last strike tick
      pos_1 = 5'd5;
      ticks(8);
      check("t4_strike", 16'(strike), 16'd1);
      ticks(3);
      check("t4_no_dmg", 16'(dmg1_n), 16'd0);
      pos_1 = lane_of(exp_lane);
      @(negedge clk);
      check("t4_dmg1_pulse", 16'(damage_1), 16'd1);
      check("t4_dmg0_quiet", 16'(damage_0), 16'd0);
      check("t4_in_strike",  16'(strike),   16'd1);
      do_tick();
      check("t4_cool",     16'(strike), 16'd0);
      check("t4_dmg1_cnt", 16'(dmg1_n), 16'd1);
      pos_1 = 5'd31;
      ticks(16);

      // 3. player 0 shielded on the lane, shield dropped mid-strike
      exp_lane = lfsr_m[0];
      do_tick();
      check("t3_target", 16'(target),   16'd0);
      check("t3_lane",   16'(atk_lane), 16'(exp_lane));
      pos_0 = lane_of(exp_lane);
      hit_0 = 1'b1;
      ticks(8);
      check("t3_strike", 16'(strike), 16'd1);
      ticks(2);
      check("t3_shielded", 16'(dmg0_n), 16'd1);
      hit_0 = 1'b0;
      @(negedge clk);
      check("t3_dmg_pulse", 16'(damage_0), 16'd1);
      @(negedge clk);
      check("t3_dmg_end", 16'(damage_0), 16'd0);
      ticks(2);
      check("t3_cool",     16'(strike), 16'd0);
      check("t3_dmg0_cnt", 16'(dmg0_n), 16'd2);
      check("t3_atkcnt",   16'(attack_cnt), 16'd3);
      pos_0 = 5'd31;
      ticks(16);

      // 5. abort during warn, then enable dropped during strike
      do_tick();
      check("t5_warn",   16'(warn),   16'd1);
      check("t5_target", 16'(target), 16'd1);
      ticks(2);
      enable = 1'b0;
      @(negedge clk);
      check("t5_abort_idle", 16'(warn),       16'd0);
      check("t5_abort_nost", 16'(strike),     16'd0);
      check("t5_abort_cnt",  16'(attack_cnt), 16'd3);
      enable = 1'b1;
      do_tick();
      check("t5_rr_kept", 16'(target), 16'd1);
      ticks(8);
      check("t5_strike", 16'(strike),     16'd1);
      check("t5_atkcnt", 16'(attack_cnt), 16'd4);
      enable = 1'b0;
      ticks(3);
      check("t5_strike_hold", 16'(strike), 16'd1);
      do_tick();
      check("t5_strike_done", 16'(strike), 16'd0);
      ticks(16);
      do_tick();
      check("t5_idle_disabled", 16'(warn), 16'd0);

      // 6a. reset while striking with damage pending
      enable = 1'b1;
      exp_lane = lfsr_m[0];
      do_tick();
      check("t6_target", 16'(target), 16'd0);
      pos_0 = lane_of(exp_lane);
      ticks(8);
      check("t6_atkcnt", 16'(attack_cnt), 16'd5);
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_dmg",    16'(damage_0),   16'd0);
      check("t6_rst_strike", 16'(strike),     16'd0);
      check("t6_rst_target", 16'(target),     16'd0);
      check("t6_rst_atkcnt", 16'(attack_cnt), 16'd0);
      rst = 1'b1;
      pos_0 = 5'd31;
      lfsr_m = 8'hA5;

      // 6b. continuous ticks: 29 ticks per attack, saturate after 255
      tick = 1'b1;
      repeat (9 * 29) @(negedge clk);
      check("t6_cnt9", 16'(attack_cnt), 16'd9);
      repeat (251 * 29) @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      check("t6_saturate",   16'(attack_cnt), 16'd255);
      check("never_both",    16'(both_n),     16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
